// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and defaults for the UART quaternion frame controller.
package uart_frame_pkg;
    typedef enum logic [1:0] {HUNT_H0, HUNT_H1, PAYLOAD, CHECK} state_t;
    localparam logic [7:0] HDR0_DEF = 8'hAA;
    localparam logic [7:0] HDR1_DEF = 8'h55;
    localparam int PAYLOAD_BYTES = 8;
    typedef struct packed {
        logic signed [15:0] q3;
        logic signed [15:0] q2;
        logic signed [15:0] q1;
        logic signed [15:0] q0;
    } frame_t;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: inter-byte gap counter; pulses o_tc on its last count and wraps to zero.
module uart_gap_timer #(
    parameter int TIMEOUT_CLKS = 13020
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = $clog2(TIMEOUT_CLKS + 1);
    logic [W-1:0] r_cnt;
    assign o_tc = i_en && (r_cnt == W'(TIMEOUT_CLKS - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else if (i_clr || o_tc) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: header hunt, payload collection, XOR check and gap timeout for
// quaternion frames; publishes q0..q3 under a valid/ack handshake.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BAUD_RATE    = 115200,
    parameter int          TIMEOUT_BITS = 30,
    parameter int          TIMEOUT_CLKS = TIMEOUT_BITS * CLK_FREQ / BAUD_RATE,
    parameter logic [7:0]  HDR0         = HDR0_DEF,
    parameter logic [7:0]  HDR1         = HDR1_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic               frame_ack,
    output logic signed [15:0] q0,
    output logic signed [15:0] q1,
    output logic signed [15:0] q2,
    output logic signed [15:0] q3,
    output logic               frame_valid,
    output logic               crc_err,
    output logic               timeout_err,
    output logic               overrun,
    output logic [15:0]        frame_cnt
);
    state_t     r_state;
    logic [7:0] r_buf [PAYLOAD_BYTES];
    logic [2:0] r_idx;
    logic [7:0] r_xor;
    frame_t     r_frame;
    logic       w_hunt0, w_tc, w_tmo, w_chk, w_pub;

    assign w_hunt0 = r_state == HUNT_H0;
    assign w_tmo   = w_tc && !rx_done;
    assign w_chk   = rx_done && r_state == CHECK;
    assign w_pub   = w_chk && rx_data == r_xor;
    assign {q3, q2, q1, q0} = r_frame;

    uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap (
        .clk   (clk),
        .rst   (rst),
        .i_clr (rx_done || w_hunt0),
        .i_en  (!w_hunt0),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT_H0;
            r_idx   <= '0;
            r_xor   <= '0;
        end else if (w_tmo) begin
            r_state <= HUNT_H0;
        end else if (rx_done) begin
            case (r_state)
                HUNT_H0: r_state <= rx_data == HDR0 ? HUNT_H1 : HUNT_H0;
                HUNT_H1: begin
                    r_idx   <= '0;
                    r_xor   <= '0;
                    r_state <= rx_data == HDR1 ? PAYLOAD : rx_data == HDR0 ? HUNT_H1 : HUNT_H0;
                end
                PAYLOAD: begin
                    r_xor   <= r_xor ^ rx_data;
                    r_idx   <= r_idx + 3'd1;
                    r_state <= r_idx == 3'(PAYLOAD_BYTES - 1) ? CHECK : PAYLOAD;
                end
                default: r_state <= HUNT_H0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_done && r_state == PAYLOAD) r_buf[r_idx] <= rx_data;
    end

    // A publish outranks an ack in the same cycle: the new frame stays pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame     <= '0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            crc_err     <= w_chk && !w_pub;
            timeout_err <= w_tmo;
            if (w_pub) begin
                r_frame     <= {r_buf[7], r_buf[6], r_buf[5], r_buf[4],
                                r_buf[3], r_buf[2], r_buf[1], r_buf[0]};
                frame_cnt   <= frame_cnt + 16'd1;
                frame_valid <= 1'b1;
                if (frame_valid && !frame_ack) overrun <= 1'b1;
            end else if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized byte streams checked against a
// byte-level reference model of frame parsing, timeout and handshake.
module tb_uart_frame_ctrl;
    localparam int T = 64;

    logic        clk = 1'b0, rst = 1'b0, rx_done = 1'b0, frame_ack = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] q0, q1, q2, q3, frame_cnt;
    logic        frame_valid, crc_err, timeout_err, overrun;

    int checks = 0, errors = 0, ack_pct = 0, tmo_seen = 0;

    int          m_phase, m_gap;
    logic [7:0]  m_bytes[$];
    logic [15:0] e_q[4], e_cnt;
    bit          e_valid, e_ovr, e_crc, e_tmo;

    uart_frame_ctrl #(.TIMEOUT_CLKS(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .frame_ack(frame_ack),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .frame_valid(frame_valid), .crc_err(crc_err),
        .timeout_err(timeout_err), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_gap = 0; m_bytes.delete();
        foreach (e_q[i]) e_q[i] = '0;
        e_cnt = '0; e_valid = 0; e_ovr = 0; e_crc = 0; e_tmo = 0;
    endtask

    // m_phase: 0 = waiting for AA, 1 = seen AA, 2 = gathering payload + checksum
    task automatic model_edge(input bit dv, input logic [7:0] d, input bit ack);
        bit pub = 0;
        logic [7:0] x = '0;
        e_crc = 0; e_tmo = 0;
        if (dv) begin
            m_gap = 0;
            if (m_phase == 0) m_phase = d == 8'hAA ? 1 : 0;
            else if (m_phase == 1) begin
                if (d == 8'h55) begin m_phase = 2; m_bytes.delete(); end
                else if (d != 8'hAA) m_phase = 0;
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 9) begin
                    for (int i = 0; i < 8; i++) x ^= m_bytes[i];
                    pub = m_bytes[8] == x;
                    e_crc = !pub;
                    m_phase = 0;
                end
            end
        end else if (m_phase != 0) begin
            m_gap++;
            if (m_gap == T) begin e_tmo = 1; m_phase = 0; end
        end
        if (pub) begin
            if (e_valid && !ack) e_ovr = 1;
            e_valid = 1;
            e_cnt++;
            for (int i = 0; i < 4; i++) e_q[i] = {m_bytes[2*i+1], m_bytes[2*i]};
        end else if (ack && e_valid) begin
            e_valid = 0; e_ovr = 0;
        end
    endtask

    task automatic step(input bit dv, input logic [7:0] d, input bit ack);
        rx_done = dv; rx_data = d; frame_ack = ack;
        @(posedge clk);
        model_edge(dv, d, ack);
        @(negedge clk);
        rx_done = 0; frame_ack = 0;
        if (timeout_err === 1'b1) tmo_seen++;
        chk("q0", q0, e_q[0]); chk("q1", q1, e_q[1]);
        chk("q2", q2, e_q[2]); chk("q3", q3, e_q[3]);
        chk("frame_valid", frame_valid, e_valid); chk("overrun", overrun, e_ovr);
        chk("crc_err", crc_err, e_crc); chk("timeout_err", timeout_err, e_tmo);
        chk("frame_cnt", frame_cnt, e_cnt);
    endtask

    function automatic bit rnd_ack();
        return $urandom_range(99) < ack_pct;
    endfunction

    task automatic send(input logic [7:0] d, input int gap, input bit ack_b);
        repeat (gap - 1) step(0, 8'h00, rnd_ack());
        step(1, d, ack_b);
    endtask

    task automatic send_frame(input logic [63:0] p, input logic [7:0] delta, input bit ack_last);
        logic [7:0] x = '0;
        send(8'hAA, 10, rnd_ack());
        send(8'h55, 10, rnd_ack());
        for (int i = 0; i < 8; i++) begin
            send(p[8*i +: 8], 10, rnd_ack());
            x ^= p[8*i +: 8];
        end
        send(x ^ delta, 10, ack_last);
    endtask

    function automatic logic [63:0] rnd_payload();
        logic [63:0] p = {$urandom, $urandom};
        if ($urandom_range(3) == 0) p[8*$urandom_range(7) +: 8] = $urandom_range(1) ? 8'hAA : 8'h55;
        return p;
    endfunction

    initial begin
        int t0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", frame_valid, 0); chk("rst_cnt", frame_cnt, 0); chk("rst_q0", q0, 0);
        rst = 1;
        step(0, 8'h00, 0);

        send_frame(64'h0004_0003_0002_0001, 8'h00, 0);
        chk("t1_q0", q0, 16'h0001); chk("t1_q3", q3, 16'h0004);
        chk("t1_valid", frame_valid, 1); chk("t1_cnt", frame_cnt, 1);

        send_frame(64'h0004_0003_0002_0001, 8'h01, 0);
        chk("t2_cnt", frame_cnt, 1);
        step(0, 8'h00, 1);

        send(8'hAA, 10, 0);
        send_frame(64'h0001_0000_8000_7FFF, 8'h00, 0);
        chk("t3_q0", q0, 16'h7FFF); chk("t3_q1", q1, 16'h8000);
        chk("t3_q2", q2, 16'h0000); chk("t3_q3", q3, 16'h0001);
        step(0, 8'h00, 1);

        t0 = tmo_seen;
        send(8'hAA, 10, 0); send(8'h55, 10, 0);
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 10, 0);
        repeat (100) step(0, 8'h00, 0);
        chk("t4_tmo_pulses", tmo_seen - t0, 1);
        send_frame(64'h1111_2222_3333_4444, 8'h00, 0);
        chk("t4_cnt", frame_cnt, 3);

        step(0, 8'h00, 1);
        send_frame(64'h0101_0202_0303_0404, 8'h00, 0);
        send_frame(64'h0505_0606_0707_0808, 8'h00, 0);
        chk("t5_ovr", overrun, 1); chk("t5_q0", q0, 16'h0808);
        step(0, 8'h00, 1);
        chk("t5_ack_valid", frame_valid, 0); chk("t5_ack_ovr", overrun, 0);
        send_frame(64'h0909_0A0A_0B0B_0C0C, 8'h00, 0);
        send_frame(64'h0D0D_0E0E_0F0F_1010, 8'h00, 1);
        chk("t5_same_ovr", overrun, 0); chk("t5_same_valid", frame_valid, 1);

        send(8'hAA, 10, 0); send(8'h55, 10, 0);
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 10, 0);
        repeat (9) step(0, 8'h00, 0);
        rx_done = 1; rx_data = 8'h24;
        #2 rst = 0;
        #1;
        chk("t6_rst_valid", frame_valid, 0); chk("t6_rst_cnt", frame_cnt, 0);
        chk("t6_rst_q1", q1, 0); chk("t6_rst_ovr", overrun, 0);
        rx_done = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1;
        send_frame(64'h0004_0003_0002_0001, 8'h00, 0);
        chk("t6_cnt", frame_cnt, 1);

        ack_pct = 20;
        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(9);
            if (kind <= 5) send_frame(rnd_payload(), 8'h00, rnd_ack());
            else if (kind == 6) send_frame(rnd_payload(), 8'($urandom_range(255, 1)), rnd_ack());
            else if (kind == 7) repeat ($urandom_range(3, 1)) send(8'($urandom), 10, rnd_ack());
            else if (kind == 8) begin
                send(8'hAA, 10, 0); send(8'h55, 10, 0);
                repeat ($urandom_range(8)) send(8'($urandom), 10, 0);
                repeat (T + 6) step(0, 8'h00, rnd_ack());
            end else begin
                logic [63:0] p = rnd_payload();
                logic [7:0] x = '0;
                int g = T - 1 + $urandom_range(2);
                send(8'hAA, 10, 0); send(8'h55, 10, 0);
                for (int i = 0; i < 8; i++) begin
                    send(p[8*i +: 8], i == 4 ? g : 10, 0);
                    x ^= p[8*i +: 8];
                end
                send(x, 10, rnd_ack());
            end
        end
        repeat (T + 4) step(0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
